mux_n_pipe: RTL and testbench



---
 rtl/mux_n_pipe.sv | 109 ++++++++++
 tb/tb_mux_n_pipe.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mux_n_pipe
// Purpose  : NUM_IN x WIDTH select mux feeding a 2-entry skid buffer with
//            valid/ready on both sides. Optional macro MUX_BYPASS_EN enables a
//            zero-latency pass-through while the buffer is empty.
// Revision : 1.0  initial release
// ============================================================================
module mux_n_pipe #(
   parameter  int WIDTH  = 32,
   parameter  int NUM_IN = 4,
   localparam int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [SEL_W-1:0]        sel,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_sel_err
);

   logic [WIDTH-1:0] w_mux_data;
   logic             w_mux_err;

   logic [1:0]       r_count;
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [WIDTH-1:0] r_mem_data [2];
   logic [1:0]       r_mem_err;

   logic             w_empty;
   logic             w_full;
   logic             w_bypass;
   logic             w_accept;
   logic             w_push;
   logic             w_pop;
   logic             w_head_ptr;

   // An unmatched select leaves zero data with the error flag raised.
   always_comb begin
      w_mux_data = '0;
      w_mux_err  = 1'b1;
      for (int k = 0; k < NUM_IN; k++) begin
         if (sel == k[SEL_W-1:0]) begin
            w_mux_data = in_data[k*WIDTH +: WIDTH];
            w_mux_err  = 1'b0;
         end
      end
   end

   assign w_empty  = (r_count == 2'd0);
   assign w_full   = (r_count == 2'd2);
   assign in_ready = ~w_full & ~reset;

`ifdef MUX_BYPASS_EN
   assign w_bypass = w_empty & out_ready & ~reset;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_accept = in_valid & in_ready;
   assign w_push   = w_accept & ~w_bypass;
   assign w_pop    = ~w_empty & out_ready;

   // When empty, the slot behind the read pointer holds the last beat shown.
   assign w_head_ptr = w_empty ? ~r_rd_ptr : r_rd_ptr;

   always_comb begin
      out_valid   = ~w_empty;
      out_data    = r_mem_data[w_head_ptr];
      out_sel_err = ~w_empty & r_mem_err[w_head_ptr];
      if (w_bypass && in_valid) begin
         out_valid   = 1'b1;
         out_data    = w_mux_data;
         out_sel_err = w_mux_err;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count       <= 2'd0;
         r_wr_ptr      <= 1'b0;
         r_rd_ptr      <= 1'b0;
         r_mem_err     <= 2'b00;
         r_mem_data[0] <= '0;
         r_mem_data[1] <= '0;
      end else begin
         if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_mux_data;
            r_mem_err[r_wr_ptr]  <= w_mux_err;
            r_wr_ptr             <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mux_n_pipe.sv
`default_nettype none
// Bench for mux_n_pipe: a 4-input and a 3-input instance share one stimulus
// stream and are compared against a queue-based model of the buffer.
module tb_mux_n_pipe;
   localparam int W = 32;
`ifdef MUX_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           in_valid = 1'b0;
   logic           out_ready = 1'b0;
   logic [1:0]     sel = 2'd0;
   logic [4*W-1:0] in_data = '0;

   logic           in_ready4, out_valid4, err4;
   logic           in_ready3, out_valid3, err3;
   logic [W-1:0]   data4, data3;

   int             n_checks = 0;
   int             n_fail = 0;

   logic [W:0]     q4[$];
   logic [W:0]     q3[$];
   logic [W-1:0]   last4 = '0;
   logic [W-1:0]   last3 = '0;

   always #5 clk = ~clk;

   mux_n_pipe #(.WIDTH(W), .NUM_IN(4)) u_dut4 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
      .sel(sel), .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready),
      .out_data(data4), .out_sel_err(err4)
   );

   mux_n_pipe #(.WIDTH(W), .NUM_IN(3)) u_dut3 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready3),
      .sel(sel), .in_data(in_data[3*W-1:0]), .out_valid(out_valid3), .out_ready(out_ready),
      .out_data(data3), .out_sel_err(err3)
   );

   // ---------------- reference model ----------------
   function automatic logic [W:0] ref_beat(int n, logic [1:0] s, logic [4*W-1:0] d);
      if (int'(s) < n) return {1'b0, d[int'(s)*W +: W]};
      return {1'b1, {W{1'b0}}};
   endfunction

   function automatic int qsize(int w);
      return (w == 0) ? q4.size() : q3.size();
   endfunction

   function automatic logic [W:0] qhead(int w);
      return (w == 0) ? q4[0] : q3[0];
   endfunction

   function automatic bit m_byp(int w);
      return BYP && (qsize(w) == 0) && (out_ready === 1'b1);
   endfunction

   function automatic bit e_valid(int w);
      return (qsize(w) != 0) || (m_byp(w) && in_valid);
   endfunction

   function automatic logic [W:0] e_head(int w);
      return (qsize(w) != 0) ? qhead(w) : ref_beat((w == 0) ? 4 : 3, sel, in_data);
   endfunction

   function automatic bit e_ready(int w);
      return qsize(w) < 2;
   endfunction

   task automatic rand_data();
      in_data = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // Advance one clock edge and update the model with what that edge did.
   task automatic tick();
      bit         acc[2];
      bit         pop[2];
      bit         bf[2];
      logic [W:0] nb[2];
      logic [W:0] tmp;
      for (int w = 0; w < 2; w++) begin
         acc[w] = in_valid && e_ready(w);
         pop[w] = e_valid(w) && out_ready;
         bf[w]  = m_byp(w) && in_valid;
         nb[w]  = ref_beat((w == 0) ? 4 : 3, sel, in_data);
      end
      @(posedge clk);
      if (!bf[0]) begin
         if (pop[0]) begin tmp = q4.pop_front(); last4 = tmp[W-1:0]; end
         if (acc[0]) q4.push_back(nb[0]);
      end
      if (!bf[1]) begin
         if (pop[1]) begin tmp = q3.pop_front(); last3 = tmp[W-1:0]; end
         if (acc[1]) q3.push_back(nb[1]);
      end
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; sel = 2'd2; rand_data();
      #2;
      n_checks++;
      if ({out_valid4, in_ready4, err4, data4} !== '0) begin
         n_fail++;
         $display("FAIL reset4: valid=%0b ready=%0b err=%0b data=%h, expected all zero", out_valid4, in_ready4, err4, data4);
      end
      n_checks++;
      if ({out_valid3, in_ready3, err3, data3} !== '0) begin
         n_fail++;
         $display("FAIL reset3: valid=%0b ready=%0b err=%0b data=%h, expected all zero", out_valid3, in_ready3, err3, data3);
      end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid4 !== 1'b0 || in_ready4 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_edge: valid=%0b ready=%0b, expected 0 0", out_valid4, in_ready4);
      end
      reset = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: ready=%0b valid=%0b, expected 1 0", in_ready4, out_valid4);
      end
      tick();
   endtask

   task automatic test_single_beat();
      out_ready = 1'b1; sel = 2'd2;
      for (int i = 0; i < 4; i++) begin
         in_valid = (i == 0);
         rand_data();
         in_data[2*W +: W] = 32'hDEAD_BEEF;
         @(negedge clk);
         n_checks++;
         if (out_valid4 !== e_valid(0) || in_ready4 !== e_ready(0)) begin
            n_fail++;
            $display("FAIL single_hs cyc%0d: valid=%0b ready=%0b, expected %0b %0b", i, out_valid4, in_ready4, e_valid(0), e_ready(0));
         end
         if (e_valid(0)) begin
            n_checks++;
            if ({err4, data4} !== {1'b0, 32'hDEAD_BEEF}) begin
               n_fail++;
               $display("FAIL single_data cyc%0d: err=%0b data=%h, expected 0 deadbeef", i, err4, data4);
            end
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] order [3];
      int           k;
      bit           c_done;
      order[0] = 32'd1; order[1] = 32'd2; order[2] = 32'd3;
      k = 0; c_done = 1'b0; sel = 2'd0;
      for (int i = 0; i < 10; i++) begin
         out_ready = (i >= 4);
         in_valid  = (i < 2) || !c_done;
         in_data   = {$urandom, $urandom, $urandom, (i == 0) ? 32'd1 : (i == 1) ? 32'd2 : 32'd3};
         @(negedge clk);
         n_checks++;
         if (out_valid4 !== e_valid(0) || in_ready4 !== e_ready(0)) begin
            n_fail++;
            $display("FAIL bp_hs cyc%0d: valid=%0b ready=%0b, expected %0b %0b", i, out_valid4, in_ready4, e_valid(0), e_ready(0));
         end
         if (i == 2 || i == 3) begin
            n_checks++;
            if (in_ready4 !== 1'b0) begin
               n_fail++;
               $display("FAIL bp_full cyc%0d: in_ready=%0b, expected 0", i, in_ready4);
            end
         end
         if (out_valid4 === 1'b1 && out_ready && k < 3) begin
            n_checks++;
            if (data4 !== order[k]) begin
               n_fail++;
               $display("FAIL bp_order beat%0d: data=%h, expected %h", k, data4, order[k]);
            end
            k++;
         end
         if (i >= 2 && in_valid && e_ready(0)) c_done = 1'b1;
         tick();
      end
      n_checks++;
      if (k != 3 || in_ready4 !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_drain: beats=%0d in_ready=%0b, expected 3 1", k, in_ready4);
      end
   endtask

   task automatic test_streaming();
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         in_valid = (i < 8);
         sel      = 2'(i % 4);
         rand_data();
         @(negedge clk);
         n_checks++;
         if (out_valid4 !== e_valid(0) || in_ready4 !== e_ready(0)) begin
            n_fail++;
            $display("FAIL stream_hs cyc%0d: valid=%0b ready=%0b, expected %0b %0b", i, out_valid4, in_ready4, e_valid(0), e_ready(0));
         end
         if (e_valid(0)) begin
            n_checks++;
            if ({err4, data4} !== e_head(0)) begin
               n_fail++;
               $display("FAIL stream_data cyc%0d: %h, expected %h", i, {err4, data4}, e_head(0));
            end
         end
         if (i >= (BYP ? 0 : 1) && i <= (BYP ? 7 : 8)) begin
            n_checks++;
            if (out_valid4 !== 1'b1) begin
               n_fail++;
               $display("FAIL stream_bubble cyc%0d: out_valid=%0b, expected 1", i, out_valid4);
            end
         end
         tick();
      end
   endtask

   task automatic test_sel_err();
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         in_valid = (i < 9);
         sel      = 2'((i + 1) % 4);
         rand_data();
         @(negedge clk);
         n_checks++;
         if (out_valid3 !== e_valid(1) || in_ready3 !== e_ready(1)) begin
            n_fail++;
            $display("FAIL selerr_hs cyc%0d: valid=%0b ready=%0b, expected %0b %0b", i, out_valid3, in_ready3, e_valid(1), e_ready(1));
         end
         if (e_valid(1)) begin
            n_checks++;
            if ({err3, data3} !== e_head(1)) begin
               n_fail++;
               $display("FAIL selerr_data cyc%0d: err=%0b data=%h, expected %h", i, err3, data3, e_head(1));
            end
         end
         tick();
      end
   endtask

   task automatic test_simultaneous();
      out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1; rand_data();
      tick();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = (i < 6);
         sel      = 2'($urandom_range(0, 3));
         rand_data();
         @(negedge clk);
         n_checks++;
         if (out_valid4 !== e_valid(0) || in_ready4 !== e_ready(0)) begin
            n_fail++;
            $display("FAIL simul_hs cyc%0d: valid=%0b ready=%0b, expected %0b %0b", i, out_valid4, in_ready4, e_valid(0), e_ready(0));
         end
         if (i < 6) begin
            n_checks++;
            if (out_valid4 !== 1'b1 || in_ready4 !== 1'b1) begin
               n_fail++;
               $display("FAIL simul_level cyc%0d: valid=%0b ready=%0b, expected 1 1", i, out_valid4, in_ready4);
            end
         end
         if (e_valid(0)) begin
            n_checks++;
            if ({err4, data4} !== e_head(0)) begin
               n_fail++;
               $display("FAIL simul_data cyc%0d: %h, expected %h", i, {err4, data4}, e_head(0));
            end
         end
         tick();
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         sel       = 2'($urandom_range(0, 3));
         rand_data();
         @(negedge clk);
         n_checks++;
         if (out_valid4 !== e_valid(0) || in_ready4 !== e_ready(0) ||
             out_valid3 !== e_valid(1) || in_ready3 !== e_ready(1)) begin
            n_fail++;
            $display("FAIL rand_hs cyc%0d: v4=%0b r4=%0b v3=%0b r3=%0b, expected %0b %0b %0b %0b", i,
                     out_valid4, in_ready4, out_valid3, in_ready3, e_valid(0), e_ready(0), e_valid(1), e_ready(1));
         end
         if (e_valid(0)) begin
            n_checks++;
            if ({err4, data4} !== e_head(0)) begin
               n_fail++;
               $display("FAIL rand_data4 cyc%0d: %h, expected %h", i, {err4, data4}, e_head(0));
            end
         end
         if (e_valid(1)) begin
            n_checks++;
            if ({err3, data3} !== e_head(1)) begin
               n_fail++;
               $display("FAIL rand_data3 cyc%0d: %h, expected %h", i, {err3, data3}, e_head(1));
            end
         end
         if (!BYP && !e_valid(0)) begin
            n_checks++;
            if (data4 !== last4) begin
               n_fail++;
               $display("FAIL rand_hold cyc%0d: data=%h, expected held %h", i, data4, last4);
            end
         end
         tick();
      end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         sel = 2'($urandom_range(0, 3));
         rand_data();
         tick();
      end
      #2;
      reset = 1'b1;
      q4.delete(); q3.delete();
      last4 = '0; last3 = '0;
      #1;
      n_checks++;
      if ({out_valid4, in_ready4, err4, data4} !== '0 || {out_valid3, in_ready3, err3, data3} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: v4=%0b r4=%0b d4=%h v3=%0b r3=%0b d3=%h, expected all zero",
                  out_valid4, in_ready4, data4, out_valid3, in_ready3, data3);
      end
      @(posedge clk); #3;
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rand_data();
         @(negedge clk);
         n_checks++;
         if (out_valid4 !== 1'b0 || out_valid3 !== 1'b0 || in_ready4 !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset cyc%0d: v4=%0b v3=%0b r4=%0b, expected 0 0 1", i, out_valid4, out_valid3, in_ready4);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_backpressure();
      test_streaming();
      test_sel_err();
      test_simultaneous();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
